// File: rtl/div_if.sv
// div_if: EX-stage request/result bundle for the multi-cycle divider
interface div_if;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    modport master (output signed_div, opdata1, opdata2, start, annul, input result, ready);
    modport slave  (input signed_div, opdata1, opdata2, start, annul, output result, ready);
endinterface

// File: rtl/div.sv
// div: restoring one-bit-per-cycle 32-bit divider returning {remainder, quotient}
module div (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;
    state_t      state, next;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [31:0] divisor, abs1, abs2, q, r;
    logic        neg_q, neg_r;
    logic [63:0] res;
    logic [32:0] t;
    assign abs1 = (bus.signed_div && bus.opdata1[31]) ? -bus.opdata1 : bus.opdata1;
    assign abs2 = (bus.signed_div && bus.opdata2[31]) ? -bus.opdata2 : bus.opdata2;
    assign t    = {1'b0, work[63:32]} - {1'b0, divisor};
    assign q    = neg_q ? -work[31:0] : work[31:0];
    assign r    = neg_r ? -work[64:33] : work[64:33];
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (bus.start && !bus.annul) ? ((bus.opdata2 == 32'd0) ? BYZERO : RUN) : IDLE;
            BYZERO:  next = DONE;
            RUN:     next = bus.annul ? IDLE : (cnt == 6'd32) ? DONE : RUN;
            DONE:    next = bus.start ? DONE : IDLE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 6'd0;
            work    <= 65'd0;
            divisor <= 32'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            res     <= 64'd0;
        end else begin
            case (state)
                IDLE: if (next == RUN) begin
                    neg_q   <= bus.signed_div && (bus.opdata1[31] ^ bus.opdata2[31]);
                    neg_r   <= bus.signed_div && bus.opdata1[31];
                    divisor <= abs2;
                    work    <= {32'd0, abs1, 1'b0};
                    cnt     <= 6'd0;
                end
                BYZERO: res <= 64'd0;
                RUN: if (cnt != 6'd32) begin
                    // A borrow means the divisor did not fit: shift in a zero quotient bit
                    work <= t[32] ? {work[63:0], 1'b0} : {t[31:0], work[31:0], 1'b1};
                    cnt  <= cnt + 6'd1;
                end else res <= {r, q};
                DONE: if (!bus.start) res <= 64'd0;
                default: ;
            endcase
        end
    end
    always_comb begin
        bus.ready  = state == DONE;
        bus.result = (state == DONE) ? res : 64'd0;
    end
endmodule

// File: tb/tb_div.sv
// tb_div: directed checks of div against a cycle-level arithmetic model
module tb_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   armed  = 1'b0;
    div_if bus();
    div dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Model: pending result counts down edges until it becomes visible
    int          left = 0;
    bit          m_byz = 1'b0;
    logic        m_ready = 1'b0;
    logic [63:0] m_res = 64'd0, m_exp = 64'd0;
    always @(posedge clk) begin
        if (rst) begin
            left = 0; m_ready = 1'b0; m_res = 64'd0;
        end else if (m_ready) begin
            if (!bus.start) begin m_ready = 1'b0; m_res = 64'd0; end
        end else if (left > 0) begin
            if (bus.annul && !m_byz) left = 0;
            else begin
                left = left - 1;
                if (left == 0) begin m_ready = 1'b1; m_res = m_exp; end
            end
        end else if (bus.start && !bus.annul) begin
            m_exp = model(bus.signed_div, bus.opdata1, bus.opdata2);
            m_byz = bus.opdata2 == 32'd0;
            left  = m_byz ? 1 : 33;
        end
    end

    always @(negedge clk) if (armed) begin
        checks++;
        if (bus.ready !== m_ready || bus.result !== m_res) begin
            errors++;
            $display("FAIL cycle: ready=%0b result=%h required ready=%0b result=%h", bus.ready, bus.result, m_ready, m_res);
        end
    end

    task automatic expect64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.signed_div = sgn; bus.opdata1 = a; bus.opdata2 = b; bus.start = 1'b1; bus.annul = 1'b0;
    endtask

    task automatic run_op(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] req, input int hold);
        int k;
        launch(sgn, a, b);
        k = 0;
        while (!bus.ready && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 3) begin bus.opdata1 = ~a; bus.opdata2 = 32'h5; bus.signed_div = ~sgn; end
        end
        expect64({name, " latency"}, 64'(k - 1), (b == 32'd0) ? 64'd1 : 64'd33);
        expect64({name, " result"}, bus.result, req);
        repeat (hold) begin
            @(negedge clk);
            expect64({name, " hold"}, {bus.result[62:0], bus.ready}, {req[62:0], 1'b1});
        end
        bus.start = 1'b0;
        @(negedge clk);
        expect64({name, " release"}, {bus.result, 63'd0, bus.ready}, 127'd0);
    endtask

    initial begin
        bus.signed_div = 1'b0; bus.opdata1 = 32'd0; bus.opdata2 = 32'd0; bus.start = 1'b0; bus.annul = 1'b0;
        @(posedge clk); #1;
        armed = 1'b1;
        @(negedge clk);
        expect64("reset", {bus.result, 63'd0, bus.ready}, 127'd0);
        rst = 1'b0;
        expect64("model 100/7", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        expect64("model -7/2", model(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        expect64("model min/-1", model(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
        run_op("u100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0);
        run_op("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0);
        run_op("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0);
        run_op("uFFFFFFF9/2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 5);
        run_op("by zero", 1'b1, 32'd1234, 32'd0, 64'd0, 0);
        // start and annul together in IDLE must not launch anything
        launch(1'b0, 32'd50, 32'd5);
        bus.annul = 1'b1;
        repeat (3) @(negedge clk);
        expect64("start+annul idle", {63'd0, bus.ready}, 64'd0);
        bus.start = 1'b0; bus.annul = 1'b0;
        launch(1'b0, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        bus.annul = 1'b1; bus.start = 1'b0;
        @(negedge clk);
        bus.annul = 1'b0;
        begin
            int seen = 0;
            repeat (40) begin @(negedge clk); if (bus.ready) seen++; end
            expect64("annul no ready", 64'(seen), 64'd0);
        end
        run_op("u9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 0);
        launch(1'b1, 32'd1000, 32'd3);
        repeat (21) @(negedge clk);
        rst = 1'b1; bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expect64("reset mid-run", {bus.result, 63'd0, bus.ready}, 127'd0);
        run_op("smin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 2);
        run_op("s-100/-7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
